multiply_divide_unit: RTL and testbench
=======================================

// Module: multiply_divide_unit
// PURPOSE
//  Iterative multi-cycle integer multiply/divide unit (RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//  Handles the arithmetic the single-cycle ALU does not. It consumes operands via a valid/ready request
//  port and returns the result via a valid/ready response port. Sits beside the ALU in execute; the core
//  stalls while in_ready or out_valid block.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count = WIDTH; counter width = $clog2(WIDTH)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  flush      in   1      abort any in-flight operation (pipeline flush)
//  in_valid   in   1      request valid
//  in_ready   out  1      unit can accept a request
//  op         in   3      000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  in1        in   WIDTH  rs1 (multiplicand / dividend)
//  in2        in   WIDTH  rs2 (multiplier / divisor)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result
//  out        out  WIDTH  result
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE, count=0, out=0, out_valid=0, in_ready=1; dominates all inputs.
//  FSM: IDLE -> BUSY on in_valid&in_ready (accept edge T; op/in1/in2 latched, signs recorded).
//       BUSY: one shift-add (mul) or restoring shift-subtract (div) step per cycle, WIDTH steps.
//       BUSY -> DONE after the WIDTH-th step; out_valid=1 from cycle T+WIDTH+1 (33 for WIDTH=32).
//       DONE: out and out_valid held stable until out_ready; DONE&out_ready -> IDLE next edge.
//  in_ready = (state==IDLE); there is no back-to-back accept from DONE (1 idle cycle minimum).
//  flush: any state -> IDLE next edge, out_valid=0, result discarded; flush beats in_valid same cycle.
//  Signed handling: MULH/DIV/REM operands are signed; MULHSU is in1 signed, in2 unsigned. Iterate on
//   magnitudes; negate the result if signs differ (quotient/product) or if the dividend is negative (remainder).
//  Results: MUL = low WIDTH of the 2*WIDTH product; MULH* = high WIDTH.
//  Div-by-zero: DIV/DIVU quotient = all ones; REM/REMU = in1.
//  Overflow (DIV only): in1=most negative, in2=-1 gives quotient = in1, REM = 0.
//  out is 0 whenever out_valid=0.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: div-by-zero and signed overflow skip BUSY.
//   IDLE -> DONE directly, out_valid at T+1. All other ops are unchanged.
//  Not defined: every op takes fixed latency T+WIDTH+1; special results come from the same final fixup.
// TESTING
//  1. MUL 7 x -3 (0xFFFFFFFD) -> out=0xFFFFFFEB, out_valid at T+33, in_ready=0 during BUSY.
//  2. MULH/MULHU/MULHSU 0x80000000 x 0xFFFFFFFF -> 0x00000000 / 0x7FFFFFFF / 0x80000000.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4. DIV x/0 -> 0xFFFFFFFF, REM x/0 -> x; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//     Latency is T+1 with MULDIV_EARLY_OUT_EN, T+33 without.
//  5. Hold out_ready=0 for 10 cycles in DONE -> out/out_valid stable; then pulse out_ready ->
//     IDLE, in_ready=1 next cycle.
//  6. flush at BUSY step 5, and reset mid-BUSY -> IDLE next edge, out_valid never asserts.
//     Then a new MUL 3x4 -> 12.

Source files
------------

// File: rtl/multiply_divide_unit.sv
// multiply_divide_unit
//   Iterative RV32M multiply/divide unit. One shift-add (multiply) or
//   restoring shift-subtract (divide) step per cycle, WIDTH steps per op.
//   Operands are converted to magnitudes on accept; the sign fixup and the
//   divide-by-zero / signed-overflow special results are applied
//   combinationally from the held datapath registers in DONE.
//
//   Optional feature macro: MULDIV_EARLY_OUT_EN
//     defined     : divide-by-zero and signed overflow go IDLE -> DONE directly
//     not defined : every op takes the full WIDTH iterations
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   flush      abort any in-flight operation
//   in_valid   request valid
//   in_ready   unit idle and able to accept
//   op         000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//   in1        rs1 (multiplicand / dividend)
//   in2        rs2 (multiplier / divisor)
//   out_valid  result valid
//   out_ready  consumer takes result
//   out        result, zero while out_valid is low
module multiply_divide_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    count;
   // hi/lo: product accumulator / multiplier for multiply,
   //        partial remainder / dividend-shifting-into-quotient for divide
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] b;        // multiplicand or divisor magnitude
   logic [WIDTH-1:0] in1_q;    // raw rs1, needed for special divide results
   logic             is_div;
   logic             is_rem;
   logic             want_hi;
   logic             neg_res;
   logic             div_zero;
   logic             ovf;

   // request decode
   logic             s1_in;
   logic             s2_in;
   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;
   logic             div_zero_in;
   logic             ovf_in;
   logic             early;

   always_comb begin
      s1_in       = 1'b0;
      s2_in       = 1'b0;
      case (op)
         3'b001, 3'b100, 3'b110: begin
            s1_in = in1[WIDTH-1];
            s2_in = in2[WIDTH-1];
         end
         3'b010:  s1_in = in1[WIDTH-1];
         default: ;
      endcase
      mag1        = s1_in ? (~in1 + 1'b1) : in1;
      mag2        = s2_in ? (~in2 + 1'b1) : in2;
      div_zero_in = (in2 == '0);
      ovf_in      = op[2] & ~op[0] & (in1 == MOST_NEG) & (in2 == '1);
`ifdef MULDIV_EARLY_OUT_EN
      early       = op[2] & (div_zero_in | ovf_in);
`else
      early       = 1'b0;
`endif
   end

   // one iteration step
   logic [WIDTH:0] mul_sum;
   logic [WIDTH:0] div_shift;
   logic [WIDTH:0] div_diff;

   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
      div_shift = {hi, lo[WIDTH-1]};
      // partial remainder stays below the divisor, so bit WIDTH of the
      // difference is a clean borrow/sign flag
      div_diff  = div_shift - {1'b0, b};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         hi       <= '0;
         lo       <= '0;
         b        <= '0;
         in1_q    <= '0;
         is_div   <= 1'b0;
         is_rem   <= 1'b0;
         want_hi  <= 1'b0;
         neg_res  <= 1'b0;
         div_zero <= 1'b0;
         ovf      <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  count    <= '0;
                  hi       <= '0;
                  lo       <= op[2] ? mag1 : mag2;
                  b        <= op[2] ? mag2 : mag1;
                  in1_q    <= in1;
                  is_div   <= op[2];
                  is_rem   <= op[2] & op[1];
                  want_hi  <= ~op[2] & (op[1:0] != 2'b00);
                  neg_res  <= (op[2] & op[1]) ? s1_in : (s1_in ^ s2_in);
                  div_zero <= div_zero_in;
                  ovf      <= ovf_in;
                  state    <= early ? DONE : BUSY;
               end
            end
            BUSY: begin
               if (is_div) begin
                  if (!div_diff[WIDTH]) begin
                     hi <= div_diff[WIDTH-1:0];
                     lo <= {lo[WIDTH-2:0], 1'b1};
                  end else begin
                     hi <= div_shift[WIDTH-1:0];
                     lo <= {lo[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  hi <= mul_sum[WIDTH:1];
                  lo <= {mul_sum[0], lo[WIDTH-1:1]};
               end
               count <= count + 1'b1;
               if (count == LAST) state <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // final fixup
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   q_fix;
   logic [WIDTH-1:0]   r_fix;
   logic [WIDTH-1:0]   result;

   always_comb begin
      prod_fix = neg_res ? (~{hi, lo} + 1'b1) : {hi, lo};
      q_fix    = neg_res ? (~lo + 1'b1) : lo;
      r_fix    = neg_res ? (~hi + 1'b1) : hi;
      result   = '0;
      if (is_div) begin
         if (div_zero)  result = is_rem ? in1_q : '1;
         else if (ovf)  result = is_rem ? '0 : in1_q;
         else           result = is_rem ? r_fix : q_fix;
      end else begin
         result = want_hi ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out       = out_valid ? result : '0;

endmodule

// File: tb/tb_multiply_divide_unit.sv
module tb_multiply_divide_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;

   int total = 0;
   int bad   = 0;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int SPECIAL_LAT = 0;
`else
   localparam int SPECIAL_LAT = 32;
`endif
   localparam int NORMAL_LAT = 32;

   multiply_divide_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // issue one request, wait for result, compare latency and value, retire it
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] bb, input logic [31:0] e, input bit special);
      int lat;
      check({tag, ":rdy"}, 32'(in_ready), 32'd1);
      op = o; in1 = a; in2 = bb; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, ":busy_rdy"}, 32'(in_ready), 32'd0);
      if (!out_valid) check({tag, ":out0"}, out, 32'd0);
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      check({tag, ":lat"}, 32'(lat), 32'(special ? SPECIAL_LAT : NORMAL_LAT));
      check({tag, ":res"}, out, e);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, ":idle"}, {30'd0, out_valid, in_ready}, 32'd1);
   endtask

   initial begin
      int seen;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = 3'd0; in1 = '0; in2 = '0;
      tick(); tick();
      check("reset", {30'd0, out_valid, in_ready}, 32'd1);
      check("reset_out", out, 32'd0);
      reset = 1'b0;
      tick();

      // multiply
      run_op("mul",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
      run_op("mulh",     3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
      run_op("mulhu",    3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0);
      run_op("mulhsu",   3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
      run_op("mulhu_ff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
      run_op("mul_ff",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);

      // divide
      run_op("div",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
      run_op("rem",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
      run_op("divu",     3'b101, 32'd100,      32'd7,        32'd14,       1'b0);
      run_op("remu",     3'b111, 32'd100,      32'd7,        32'd2,        1'b0);

      // divide by zero and signed overflow
      run_op("div0",     3'b100, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1'b1);
      run_op("rem0",     3'b110, 32'h00001234, 32'd0,        32'h00001234, 1'b1);
      run_op("div0n",    3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1);
      run_op("rem0n",    3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1);
      run_op("divu0",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
      run_op("remu0",    3'b111, 32'd5,        32'd0,        32'd5,        1'b1);
      run_op("divovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
      run_op("removf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);

      // result held in DONE while out_ready is low
      op = 3'b101; in1 = 32'd100; in2 = 32'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 40 && !out_valid; i++) tick();
      for (int i = 0; i < 10; i++) begin
         check("hold", {out_valid, out[30:0]}, {1'b1, 31'd14});
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hold_release", {30'd0, out_valid, in_ready}, 32'd1);

      // flush wins over a same-cycle request
      op = 3'b000; in1 = 32'd3; in2 = 32'd4; in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      check("flush_vs_req", {30'd0, out_valid, in_ready}, 32'd1);

      // flush mid-BUSY
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy", {30'd0, out_valid, in_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen++;
         tick();
      end
      check("flush_no_valid", 32'(seen), 32'd0);

      // reset mid-BUSY
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("reset_busy", {30'd0, out_valid, in_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen++;
         tick();
      end
      check("reset_no_valid", 32'(seen), 32'd0);

      run_op("mul_after", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
